wb_write_port: RTL and testbench

//  Write-side front end of the 32x32 register file. Merges the in-order pipeline WB result with
//  out-of-order results from long-latency units (mul/div) into the single regfile write port
//  (we/wn/d). Queues long-latency results, resolves WAW against younger WB writes, and exports a

---
 rtl/wb_write_port.sv | 95 +++++++++
 tb/tb_wb_write_port.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_port.sv
// wb_write_port: merges pipeline WB and queued long-latency results onto the regfile write port
// optional WBQ_BYPASS_EN: valid ld result loads the outputs directly when queue and WB are idle
module wb_write_port #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wb_we,
  input  logic [4:0]       wb_wn,
  input  logic [WIDTH-1:0] wb_d,
  input  logic             ld_valid,
  input  logic [4:0]       ld_wn,
  input  logic [WIDTH-1:0] ld_d,
  output logic             ld_ready,
  output logic             we,
  output logic [4:0]       wn,
  output logic [WIDTH-1:0] d,
  output logic [31:0]      pend
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] vld, vld_n;
  logic [4:0]       qwn [DEPTH];
  logic [WIDTH-1:0] qd  [DEPTH];
  logic [AW-1:0]    hd, tl;
  logic [AW:0]      cnt;
  logic             wb_act, hd_v, pop, xfer, drop, byp, enq;
  assign wb_act   = wb_we && |wb_wn;
  assign ld_ready = cnt != (AW+1)'(DEPTH);
  assign xfer     = ld_valid && ld_ready;
  assign drop     = ~|ld_wn || (wb_act && ld_wn == wb_wn);
  // valid bits are cleared on pop, so a set bit always marks an occupied slot
  assign hd_v     = vld[hd];
  assign pop      = |cnt && (!hd_v || !wb_act);
`ifdef WBQ_BYPASS_EN
  assign byp      = xfer && !drop && !wb_act && ~|vld;
`else
  assign byp      = 1'b0;
`endif
  assign enq      = xfer && !drop && !byp;
  always_comb begin
    vld_n = vld;
    if (pop) vld_n[hd] = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (wb_act && qwn[i] == wb_wn) vld_n[i] = 1'b0;
    if (enq) vld_n[tl] = 1'b1;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      vld <= '0;
      hd  <= '0;
      tl  <= '0;
      cnt <= '0;
    end else begin
      vld <= vld_n;
      hd  <= hd + AW'(pop);
      tl  <= tl + AW'(enq);
      cnt <= cnt + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      qwn[tl] <= ld_wn;
      qd[tl]  <= ld_d;
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      we <= 1'b0;
      wn <= '0;
      d  <= '0;
    end else if (wb_act) begin
      we <= 1'b1;
      wn <= wb_wn;
      d  <= wb_d;
    end else if (hd_v) begin
      we <= 1'b1;
      wn <= qwn[hd];
      d  <= qd[hd];
    end else if (byp) begin
      we <= 1'b1;
      wn <= ld_wn;
      d  <= ld_d;
    end else begin
      we <= 1'b0;
    end
  end
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i]) pend[qwn[i]] = 1'b1;
    if (we) pend[wn] = 1'b1;
    pend[0] = 1'b0;
  end
endmodule

// File: tb/tb_wb_write_port.sv
// tb_wb_write_port: scoreboard bench for wb_write_port; expected writes queued in issue order
module tb_wb_write_port;
  logic        clk = 1'b0, clr = 1'b1;
  logic        wb_we = 1'b0, ld_valid = 1'b0;
  logic [4:0]  wb_wn = '0, ld_wn = '0;
  logic [31:0] wb_d = '0, ld_d = '0;
  logic        ld_ready, we;
  logic [4:0]  wn;
  logic [31:0] d, pend;
  logic [36:0] sb [$];
  logic [36:0] exp_e;
  int checks = 0, failures = 0;

  wb_write_port #(.DEPTH(4), .WIDTH(32)) dut (
    .clk(clk), .clr(clr), .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d),
    .ld_valid(ld_valid), .ld_wn(ld_wn), .ld_d(ld_d), .ld_ready(ld_ready),
    .we(we), .wn(wn), .d(d), .pend(pend)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected got wn=%0d d=%h required no write", wn, d);
      end else begin
        exp_e = sb.pop_front();
        if ({wn, d} !== exp_e) begin
          failures++;
          $display("FAIL write_order got wn=%0d d=%h required wn=%0d d=%h", wn, d, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic drive(input logic a, input logic [4:0] b, input logic [31:0] c,
                       input logic e, input logic [4:0] f, input logic [31:0] g);
    @(negedge clk);
    wb_we = a; wb_wn = b; wb_d = c; ld_valid = e; ld_wn = f; ld_d = g;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic exp_w(input logic [4:0] r, input logic [31:0] v);
    sb.push_back({r, v});
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
    idle();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d writes outstanding required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({we, wn, d, pend, ld_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got we=%b wn=%0d d=%h pend=%h rdy=%b required 0 0 0 0 1", we, wn, d, pend, ld_ready);
    end
    clr = 1'b0;
    exp_w(5'd10, 32'h10A);
    exp_w(5'd10, 32'h10B);
    drive(1'b1, 5'd10, 32'h10A, 1'b1, 5'd1, 32'h111);
    drive(1'b1, 5'd10, 32'h10B, 1'b1, 5'd2, 32'h222);
    idle();
    checks++;
    if (pend !== 32'h0000_0406) begin
      failures++;
      $display("FAIL reset_pre_pend got %h required %h", pend, 32'h406);
    end
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({we, pend, ld_ready} !== {1'b0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid got we=%b pend=%h rdy=%b required 0 0 1", we, pend, ld_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    repeat (3) idle();
    wait_drain("reset");
  endtask

  task automatic test_wb_priority();
    repeat (3) exp_w(5'd6, 32'h1234);
    exp_w(5'd5, 32'hAAAA);
    drive(1'b1, 5'd6, 32'h1234, 1'b1, 5'd5, 32'hAAAA);
    drive(1'b1, 5'd6, 32'h1234, 1'b0, 5'd0, 32'd0);
    checks++;
    if (pend !== 32'h0000_0060) begin
      failures++;
      $display("FAIL prio_pend_queued got %h required %h", pend, 32'h60);
    end
    drive(1'b1, 5'd6, 32'h1234, 1'b0, 5'd0, 32'd0);
    idle();
    checks++;
    if (pend[5] !== 1'b1) begin
      failures++;
      $display("FAIL prio_pend5_held got %b required 1", pend[5]);
    end
    idle();
    checks++;
    if ({we, wn, pend[5]} !== {1'b1, 5'd5, 1'b1}) begin
      failures++;
      $display("FAIL prio_pop got we=%b wn=%0d pend5=%b required 1 5 1", we, wn, pend[5]);
    end
    idle();
    checks++;
    if (pend !== 32'd0) begin
      failures++;
      $display("FAIL prio_pend_clear got %h required 0", pend);
    end
    wait_drain("prio");
  endtask

  task automatic test_full();
    for (int i = 0; i <= 4; i++) exp_w(5'd20, 32'(i));
    for (int i = 1; i <= 4; i++) exp_w(5'(i), 32'hB0 + 32'(i));
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'd20, 32'(i - 1), 1'b1, 5'(i), 32'hB0 + 32'(i));
      checks++;
      if (ld_ready !== 1'b1) begin
        failures++;
        $display("FAIL full_ready_%0d got %b required 1", i, ld_ready);
      end
    end
    drive(1'b1, 5'd20, 32'd4, 1'b1, 5'd11, 32'hBAD);
    checks++;
    if ({ld_ready, pend} !== {1'b0, 32'h0010_001E}) begin
      failures++;
      $display("FAIL full_state got rdy=%b pend=%h required 0 %h", ld_ready, pend, 32'h10001E);
    end
    idle();
    checks++;
    if (ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_held got %b required 0", ld_ready);
    end
    idle();
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_after_pop got %b required 1", ld_ready);
    end
    wait_drain("full");
  endtask

  task automatic test_waw();
    exp_w(5'd8, 32'h8);
    exp_w(5'd7, 32'h2);
    drive(1'b1, 5'd8, 32'h8, 1'b1, 5'd7, 32'h1);
    drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
    idle();
    checks++;
    if (pend !== 32'h0000_0080) begin
      failures++;
      $display("FAIL waw_pend got %h required %h", pend, 32'h80);
    end
    idle();
    checks++;
    if ({we, pend, ld_ready} !== {1'b0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL waw_squash got we=%b pend=%h rdy=%b required 0 0 1", we, pend, ld_ready);
    end
    wait_drain("waw");
  endtask

  task automatic test_corner();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL r0_ready got %b required 1", ld_ready);
    end
    idle();
    idle();
    checks++;
    if ({we, pend} !== {1'b0, 32'd0}) begin
      failures++;
      $display("FAIL r0_discard got we=%b pend=%h required 0 0", we, pend);
    end
    exp_w(5'd9, 32'h77);
    drive(1'b1, 5'd9, 32'h77, 1'b1, 5'd9, 32'h99);
    idle();
    idle();
    checks++;
    if (pend !== 32'd0) begin
      failures++;
      $display("FAIL same_edge_pend got %h required 0", pend);
    end
    wait_drain("same_edge");
    exp_w(5'd13, 32'hD);
    exp_w(5'd12, 32'hC);
    drive(1'b1, 5'd13, 32'hD, 1'b1, 5'd12, 32'hC);
    drive(1'b1, 5'd0, 32'hEE, 1'b0, 5'd0, 32'd0);
    idle();
    checks++;
    if ({we, wn} !== {1'b1, 5'd12}) begin
      failures++;
      $display("FAIL wb_r0_idle got we=%b wn=%0d required 1 12", we, wn);
    end
    wait_drain("wb_r0");
  endtask

  task automatic test_bypass();
    logic byp;
`ifdef WBQ_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    exp_w(5'd3, 32'h55);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h55);
    idle();
    checks++;
    if (we !== byp) begin
      failures++;
      $display("FAIL bypass_edge_n got we=%b required %b", we, byp);
    end
    idle();
    checks++;
    if (we !== !byp) begin
      failures++;
      $display("FAIL bypass_edge_n1 got we=%b required %b", we, !byp);
    end
    wait_drain("bypass");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 6; i++) exp_w(5'(i), 32'hC0 + 32'(i));
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'hC0 + 32'(i));
      checks++;
      if (ld_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready_%0d got %b required 1", i, ld_ready);
      end
    end
    wait_drain("b2b");
    checks++;
    if (pend !== 32'd0) begin
      failures++;
      $display("FAIL b2b_pend got %h required 0", pend);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_wb_priority();
    test_full();
    test_waw();
    test_corner();
    test_bypass();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
